// File: rtl/kronos_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter and its scoreboard.
package kronos_wb_arbiter_pkg;

    localparam int REG_W    = 5;   // register index width
    localparam int XLEN     = 32;  // register data width
    localparam int STARVE_W = 4;   // holds STARVE_LIMIT up to 15
    localparam int CNT_W    = 3;   // holds MAX_OUTSTANDING up to 7

    // Which requester owns the write port this cycle.
    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LSU, WB_CSR} wb_src_e;

    // One writeback payload: destination register and its value.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } pipeWB_t;

endpackage

// File: rtl/kronos_wb_arbiter_if.sv
// Writeback bus between decode/execute units (master) and the arbiter (slave).
interface kronos_wb_arbiter_if;

    logic        issue_vld;
    logic [4:0]  issue_rd;
    logic        issue_rdy;

    logic        alu_vld;
    logic        alu_rdy;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;

    logic        lsu_vld;
    logic        lsu_rdy;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;

    logic        csr_vld;
    logic        csr_rdy;
    logic [4:0]  csr_rd;
    logic [31:0] csr_data;

    logic        regwr_en;
    logic [4:0]  regwr_sel;
    logic [31:0] regwr_data;
    logic        regwr_pending;

    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;

    // Requesters, issue logic and decode drive requests and consume results.
    modport master (
        output issue_vld, issue_rd,
        output alu_vld, alu_rd, alu_data,
        output lsu_vld, lsu_rd, lsu_data,
        output csr_vld, csr_rd, csr_data,
        output rs1, rs2,
        input  issue_rdy, alu_rdy, lsu_rdy, csr_rdy,
        input  regwr_en, regwr_sel, regwr_data, regwr_pending,
        input  rs1_busy, rs2_busy
    );

    // The arbiter accepts requests and owns the register write port.
    modport slave (
        input  issue_vld, issue_rd,
        input  alu_vld, alu_rd, alu_data,
        input  lsu_vld, lsu_rd, lsu_data,
        input  csr_vld, csr_rd, csr_data,
        input  rs1, rs2,
        output issue_rdy, alu_rdy, lsu_rdy, csr_rdy,
        output regwr_en, regwr_sel, regwr_data, regwr_pending,
        output rs1_busy, rs2_busy
    );

endinterface

// File: rtl/kronos_wb_scoreboard.sv
// Scoreboard of long-latency destinations (loads / CSR reads) that have left
// decode but not yet been written back: a per-register bitmap plus a count
// that throttles issue at MAX_OUTSTANDING.
module kronos_wb_scoreboard
    import kronos_wb_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_en,   // accepted issue with rd != 0
    input  logic [REG_W-1:0] issue_rd,
    input  logic             clear_en,   // LSU/CSR writeback with rd != 0
    input  logic [REG_W-1:0] clear_rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             issue_rdy,
    output logic             outstanding
);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 7) begin : g_bad_max_outstanding
        $error("MAX_OUTSTANDING must be in 1..7");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [31:0]      sb_q, sb_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next bitmap: clear first so a same-register issue in this cycle wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sb_d = sb_q;
        if (clear_en) sb_d[clear_rd] = 1'b0;
        if (issue_en) sb_d[issue_rd] = 1'b1;
        sb_d[0] = 1'b0;  // x0 is never pending
    end

    // Next count: simultaneous issue and retire cancel; retire at zero holds.
    always_comb begin
        count_d = count_q;
        unique case ({issue_en, clear_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   if (count_q != '0) count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Bitmap and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the bitmap is state the decode stage trusts, so unlike a data RAM it must be reset.
            sb_q    <= '0;
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
            sb_q    <= sb_d;
            count_q <= count_d;
        end
    end

    assign rs1_busy    = (rs1 != '0) && sb_q[rs1];
    assign rs2_busy    = (rs2 != '0) && sb_q[rs2];
    assign issue_rdy   = (count_q < CNT_MAX);
    assign outstanding = (count_q != '0);

    // A writeback retiring a scoreboarded op with nothing outstanding is a protocol error.
    a_no_underflow: assert property (
        @(posedge clk) disable iff (rst) !(clear_en && !issue_en && count_q == '0)
    );

endmodule

// File: rtl/kronos_wb_arbiter.sv
// Register-file writeback arbiter. Picks one of ALU / LSU / CSR per cycle
// (LSU > CSR > ALU), registers the winner onto regwr_*, and tracks pending
// long-latency destinations for decode hazard checks.
// Build option KRONOS_WB_STARVE_GUARD_EN: when defined, an ALU request that
// has waited STARVE_LIMIT cycles is promoted above LSU and CSR; when undefined
// the priority is purely fixed and no starvation counter exists.
module kronos_wb_arbiter
    import kronos_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT    = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    kronos_wb_arbiter_if.slave   wb
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    wb_src_e grant;
    pipeWB_t win;
    logic    promote_alu;
    logic    xfer;
    logic    clear_en;
    logic    issue_en;
    logic    sb_outstanding;

    logic    regwr_en_q;
    pipeWB_t regwr_q;

`ifdef KRONOS_WB_STARVE_GUARD_EN
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q;

    // Count cycles the ALU waits while valid; clear on its transfer or when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (!wb.alu_vld || wb.alu_rdy) begin
            starve_q <= '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    assign promote_alu = (starve_q == STARVE_MAX);
`else
    assign promote_alu = 1'b0;
`endif

    // Grant selection: a starved ALU first, otherwise LSU > CSR > ALU.
    always_comb begin
        grant = WB_NONE;
        if (promote_alu && wb.alu_vld) grant = WB_ALU;
        else if (wb.lsu_vld)           grant = WB_LSU;
        else if (wb.csr_vld)           grant = WB_CSR;
        else if (wb.alu_vld)           grant = WB_ALU;
    end

    // Payload of the granted requester.
    always_comb begin
        win = '0;
        unique case (grant)
            WB_ALU:  win = '{rd: wb.alu_rd, data: wb.alu_data};
            WB_LSU:  win = '{rd: wb.lsu_rd, data: wb.lsu_data};
            WB_CSR:  win = '{rd: wb.csr_rd, data: wb.csr_data};
            default: win = '0;
        endcase
    end

    assign wb.alu_rdy = (grant == WB_ALU);
    assign wb.lsu_rdy = (grant == WB_LSU);
    assign wb.csr_rdy = (grant == WB_CSR);

    // Grant implies the requester is valid, so any grant is a transfer.
    assign xfer     = (grant != WB_NONE);
    assign clear_en = ((grant == WB_LSU) || (grant == WB_CSR)) && (win.rd != '0);
    assign issue_en = wb.issue_vld && wb.issue_rdy && (wb.issue_rd != '0);

    // Output register: one write strobe per transfer to a non-zero rd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwr_en_q <= 1'b0;
            regwr_q    <= '0;
        end else if (xfer && (win.rd != '0)) begin
            regwr_en_q <= 1'b1;
            regwr_q    <= win;
        end else begin
            regwr_en_q <= 1'b0;
        end
    end

    kronos_wb_scoreboard #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_en    (issue_en),
        .issue_rd    (wb.issue_rd),
        .clear_en    (clear_en),
        .clear_rd    (win.rd),
        .rs1         (wb.rs1),
        .rs2         (wb.rs2),
        .rs1_busy    (wb.rs1_busy),
        .rs2_busy    (wb.rs2_busy),
        .issue_rdy   (wb.issue_rdy),
        .outstanding (sb_outstanding)
    );

    assign wb.regwr_en      = regwr_en_q;
    assign wb.regwr_sel     = regwr_q.rd;
    assign wb.regwr_data    = regwr_q.data;
    assign wb.regwr_pending = sb_outstanding || regwr_en_q
                              || wb.alu_vld || wb.lsu_vld || wb.csr_vld;

endmodule
